// File: rtl/vga_timing_if.sv
// Video timing bundle between the sync generator (master) and the pixel pipeline (slave).
interface vga_timing_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               pix_en;
  logic               restart;
  logic               hsync;
  logic               vsync;
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  pix_en, restart,
    output hsync, vsync, hpos, vpos, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en, restart,
    input  hsync, vsync, hpos, vpos, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA sync generator with pixel-clock enable, programmable sync
// polarity, synchronous restart and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ADDR    = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ADDR    = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vid
);

  localparam int H_TOTAL      = H_ADDR + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_ADDR + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_ADDR + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ADDR + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0]   h_reg, h_next;
  logic [CNT_W-1:0]   v_reg, v_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               hsync_reg, hsync_next;
  logic               vsync_reg, vsync_next;
  logic               de_reg, de_next;
  logic               line_start_reg, line_start_next;
  logic               frame_start_reg, frame_start_next;
  logic               h_wrap, v_wrap;

  // Decode is done in 32-bit so a sync window ending exactly at 2^CNT_W cannot truncate.
  function automatic logic in_range(input logic [CNT_W-1:0] p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) < hi);
  endfunction

  always_comb begin
    h_next           = h_reg;
    v_next           = v_reg;
    frame_next       = frame_reg;
    hsync_next       = hsync_reg;
    vsync_next       = vsync_reg;
    de_next          = de_reg;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    h_wrap           = (h_reg == H_LAST);
    v_wrap           = (v_reg == V_LAST);

    if (vid.restart) begin
      h_next     = '0;
      v_next     = '0;
      hsync_next = ~HSYNC_POL;
      vsync_next = ~VSYNC_POL;
      de_next    = 1'b0;
    end else if (vid.pix_en) begin
      h_next = h_wrap ? '0 : h_reg + 1'b1;
      if (h_wrap) begin
        v_next = v_wrap ? '0 : v_reg + 1'b1;
        if (v_wrap) begin
          frame_next = frame_reg + 1'b1;
        end
      end
      // Decode the position being entered so outputs line up with hpos/vpos.
      hsync_next       = in_range(h_next, H_SYNC_START, H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_next       = in_range(v_next, V_SYNC_START, V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
      de_next          = in_range(h_next, 0, H_ADDR) && in_range(v_next, 0, V_ADDR);
      line_start_next  = (h_next == '0);
      frame_start_next = (h_next == '0) && (v_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg           <= '0;
      v_reg           <= '0;
      frame_reg       <= '0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      frame_reg       <= frame_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= de_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign vid.hpos        = h_reg;
  assign vid.vpos        = v_reg;
  assign vid.frame_count = frame_reg;
  assign vid.hsync       = hsync_reg;
  assign vid.vsync       = vsync_reg;
  assign vid.display_on  = de_reg;
  assign vid.line_start  = line_start_reg;
  assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a small 14x7 mode with active-high syncs.
module tb_vga_timing_gen;

  localparam int H_ADDR = 8, H_FRONT = 2, H_SYNC = 2, H_BACK = 2;
  localparam int V_ADDR = 4, V_FRONT = 1, V_SYNC = 1, V_BACK = 1;
  localparam bit HP = 1'b1, VP = 1'b1;
  localparam int CNT_W = 4, FRAME_W = 2;
  localparam int H_TOT = H_ADDR + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ADDR + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME_CLKS = H_TOT * V_TOT;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               de;
    logic               ls;
    logic               fs;
    logic [CNT_W-1:0]   h;
    logic [CNT_W-1:0]   v;
    logic [FRAME_W-1:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) vif ();

  vga_timing_gen #(
    .H_ADDR(H_ADDR), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ADDR(V_ADDR), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(CNT_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vid(vif)
  );

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  int   mh, mv, mfc;
  logic mhs, mvs, mde, mls, mfs;

  task automatic model_reset();
    mh = 0; mv = 0; mfc = 0;
    mhs = ~HP; mvs = ~VP; mde = 1'b0; mls = 1'b0; mfs = 1'b0;
  endtask

  task automatic model_step(input logic pe, input logic rs);
    if (rs) begin
      mh = 0; mv = 0;
      mhs = ~HP; mvs = ~VP; mde = 1'b0; mls = 1'b0; mfs = 1'b0;
    end else if (pe) begin
      if (mh == H_TOT - 1) begin
        mh = 0;
        if (mv == V_TOT - 1) begin
          mv = 0;
          mfc = (mfc + 1) % (1 << FRAME_W);
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
      mhs = (mh >= H_ADDR + H_FRONT && mh < H_ADDR + H_FRONT + H_SYNC) ? HP : ~HP;
      mvs = (mv >= V_ADDR + V_FRONT && mv < V_ADDR + V_FRONT + V_SYNC) ? VP : ~VP;
      mde = (mh < H_ADDR) && (mv < V_ADDR);
      mls = (mh == 0);
      mfs = (mh == 0) && (mv == 0);
    end else begin
      mls = 1'b0;
      mfs = 1'b0;
    end
  endtask

  function automatic obs_t model_out();
    obs_t r;
    r.hs = mhs; r.vs = mvs; r.de = mde; r.ls = mls; r.fs = mfs;
    r.h = CNT_W'(mh); r.v = CNT_W'(mv); r.fc = FRAME_W'(mfc);
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t r;
    r.hs = vif.hsync; r.vs = vif.vsync; r.de = vif.display_on;
    r.ls = vif.line_start; r.fs = vif.frame_start;
    r.h = vif.hpos; r.v = vif.vpos; r.fc = vif.frame_count;
    return r;
  endfunction

  // Drives one clock of stimulus, queues the expected result, returns 1 ns after the edge.
  task automatic drive(input logic pe, input logic rs);
    vif.pix_en  = pe;
    vif.restart = rs;
    model_step(pe, rs);
    exp_q.push_back(model_out());
    $display("txn t=%0t pe=%0b rs=%0b exp h=%0d v=%0d fc=%0d", $time, pe, rs, mh, mv, mfc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    vif.pix_en = 1'b1;
    vif.restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    e = model_out(); o = observe();
    total++;
    if (o !== e) begin
      $display("FAIL reset_state got=%h want=%h", o, e); bad++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    obs_t e, o;
    int fc_seq[5] = '{1, 2, 3, 0, 1};
    int k = 0;
    int since = 0;
    int fc_want;
    for (int i = 0; i < 5 * FRAME_CLKS; i++) begin
      drive(1'b1, 1'b0);
      since++;
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin
        $display("FAIL free_run cyc=%0d got=%h want=%h", i, o, e); bad++;
      end
      if (vif.frame_start === 1'b1) begin
        fc_want = (k < 5) ? fc_seq[k] : -1;
        total++;
        if (since != FRAME_CLKS || int'(vif.frame_count) != fc_want) begin
          $display("FAIL frame_seq idx=%0d period=%0d fc=%0d want period=%0d fc=%0d",
                   k, since, vif.frame_count, FRAME_CLKS, fc_want);
          bad++;
        end
        k++;
        since = 0;
      end
    end
    total++;
    if (k != 5) begin
      $display("FAIL frame_pulses got=%0d want=5", k); bad++;
    end
  endtask

  task automatic test_slow_en();
    obs_t e, o;
    int last_fs = -1;
    int pulses = 0;
    logic prev_ls = 1'b0, prev_fs = 1'b0;
    for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
      drive((i % 2) == 0, 1'b0);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin
        $display("FAIL slow_en cyc=%0d got=%h want=%h", i, o, e); bad++;
      end
      total++;
      if ((prev_ls && vif.line_start) || (prev_fs && vif.frame_start)) begin
        $display("FAIL strobe_width cyc=%0d ls=%0b fs=%0b want single-clk", i,
                 vif.line_start, vif.frame_start);
        bad++;
      end
      if (vif.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          total++;
          if (i - last_fs != 2 * FRAME_CLKS) begin
            $display("FAIL slow_period got=%0d want=%0d", i - last_fs, 2 * FRAME_CLKS); bad++;
          end
        end
        pulses++;
        last_fs = i;
      end
      prev_ls = vif.line_start;
      prev_fs = vif.frame_start;
    end
    total++;
    if (pulses < 2) begin
      $display("FAIL slow_pulses got=%0d want>=2", pulses); bad++;
    end
  endtask

  task automatic test_restart();
    obs_t e, o;
    for (int n = 0; n < 2 * FRAME_CLKS && !(mh == 5 && mv == 2); n++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin $display("FAIL restart_seek got=%h want=%h", o, e); bad++; end
    end
    drive(1'b1, 1'b1);
    e = exp_q.pop_front(); o = observe();
    total++;
    if (o !== e || vif.hpos !== 4'd0 || vif.vpos !== 4'd0 || vif.display_on !== 1'b0 ||
        vif.line_start !== 1'b0 || vif.frame_start !== 1'b0) begin
      $display("FAIL restart_park got=%h want=%h", o, e); bad++;
    end
    drive(1'b1, 1'b0);
    e = exp_q.pop_front(); o = observe();
    total++;
    if (o !== e || vif.hpos !== 4'd1 || vif.frame_start !== 1'b0) begin
      $display("FAIL restart_resume got=%h want=%h", o, e); bad++;
    end
  endtask

  task automatic test_restart_wrap();
    obs_t e, o;
    logic [FRAME_W-1:0] fc_keep;
    for (int n = 0; n < 2 * FRAME_CLKS && !(mh == H_TOT - 1 && mv == V_TOT - 1); n++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin $display("FAIL wrap_seek got=%h want=%h", o, e); bad++; end
    end
    fc_keep = FRAME_W'(mfc);
    drive(1'b1, 1'b1);
    e = exp_q.pop_front(); o = observe();
    total++;
    if (o !== e || vif.frame_start !== 1'b0 || vif.frame_count !== fc_keep) begin
      $display("FAIL restart_wrap got=%h want=%h fc_want=%0d", o, e, fc_keep); bad++;
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e || vif.hpos !== 4'd0 || vif.vpos !== 4'd0) begin
        $display("FAIL restart_hold cyc=%0d got=%h want=%h", i, o, e); bad++;
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o, rst_exp;
    int n;
    rst_exp = '0;
    rst_exp.hs = ~HP;
    rst_exp.vs = ~VP;
    for (int k = 0; k < 2 * FRAME_CLKS && mv != 5; k++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin $display("FAIL arst_seek got=%h want=%h", o, e); bad++; end
    end
    #3 rst_n = 1'b0;
    #1;
    o = observe();
    total++;
    if (o !== rst_exp) begin
      $display("FAIL arst_immediate got=%h want=%h", o, rst_exp); bad++;
    end
    @(posedge clk);
    #1;
    o = observe();
    total++;
    if (o !== rst_exp) begin
      $display("FAIL arst_held got=%h want=%h", o, rst_exp); bad++;
    end
    rst_n = 1'b1;
    model_reset();
    n = 0;
    while (n < 2 * FRAME_CLKS) begin
      drive(1'b1, 1'b0);
      n++;
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin $display("FAIL arst_run got=%h want=%h", o, e); bad++; end
      if (vif.frame_start === 1'b1) break;
    end
    total++;
    if (n != FRAME_CLKS || vif.frame_start !== 1'b1) begin
      $display("FAIL arst_first_frame got=%0d advances want=%0d", n, FRAME_CLKS); bad++;
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      e = exp_q.pop_front(); o = observe();
      total++;
      if (o !== e) begin
        $display("FAIL random cyc=%0d got=%h want=%h", i, o, e); bad++;
      end
    end
  endtask

  initial begin
    if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin
      $display("FAIL param_constraint h_tot=%0d v_tot=%0d cnt_w=%0d", H_TOT, V_TOT, CNT_W);
      $fatal(1, "timing totals exceed counter width");
    end
    test_reset();
    test_free_run();
    test_slow_en();
    test_restart();
    test_restart_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
